avst_pkt_responder: RTL
=======================

// Module: avst_pkt_responder
// PURPOSE
//   FPGA-side end of the HPS<->FPGA Avalon-ST packet link. Sinks request packets from the
//   soc_system stream source, buffers each one whole (store-and-forward), then returns a
//   response packet on a stream source feeding a soc_system str_in port. The response is a
//   header word carrying the length and status, followed by the echoed payload. Serves as
//   the loopback/bring-up peer for the matcher datapath, and as its framing front end.
// PARAMETERS
//   DATA_W      32    beat width, both directions; must be >= LEN_W+1
//   MAX_PKT     256   max payload beats kept per packet; longer packets are truncated
//   DATA_DEPTH  512   payload FIFO depth, power of 2, >= MAX_PKT
//   LEN_DEPTH   8     length/status FIFO depth (whole packets in flight), power of 2
//   LEN_W       $clog2(MAX_PKT+1), derived
// PORTS
//   clk        in   1        single clock domain
//   rst_n      in   1        asynchronous assert, active-low
//   snk_data   in   DATA_W   request payload
//   snk_valid  in   1
//   snk_ready  out  1
//   snk_sop    in   1
//   snk_eop    in   1
//   src_data   out  DATA_W   response beat
//   src_valid  out  1
//   src_ready  in   1
//   src_sop    out  1
//   src_eop    out  1
//   pkt_cnt    out  32       responses completed (header..last beat accepted), wraps
//   drop_cnt   out  32       beats dropped as orphans (no SOP seen), wraps
// BEHAVIOUR
//   - Reset: every output = 0; FIFOs empty; FSMs in IDLE. Reset asserted mid-packet discards
//     partial input and output packets; no truncated response is emitted afterwards.
//   - A beat transfers only on valid&ready. src_* hold stable while src_valid=1 && !src_ready.
//   - Ingress FSM states: IDLE, RECV, DISCARD.
//     IDLE: beat with sop -> write payload, len=1, go to RECV; if eop is also set, commit
//           the length immediately and stay in IDLE. Beat without sop -> drop it,
//           increment drop_cnt.
//     RECV: write payload, len++. eop -> commit {trunc=0,len}, go to IDLE. sop in RECV ->
//           commit the previous packet at its current length, then start a new one with
//           this beat (len=1). If the beat that reaches MAX_PKT has no eop -> commit it with
//           trunc=1 and go to DISCARD.
//     DISCARD: accept and drop beats until eop, then go to IDLE. A sop in DISCARD starts a
//           new packet, as in RECV.
//   - snk_ready = !data_full && !len_full in IDLE/RECV; held at 1 in DISCARD.
//   - Egress FSM states: IDLE, HDR, PAY (and CSUM when the feature is enabled).
//     A packet leaves only once its length entry is committed. The header is offered no
//     earlier than 1 cycle after the committing beat.
//     Header word: [DATA_W-1]=trunc; [LEN_W-1:0]=len; other bits 0; src_sop=1.
//     PAY emits len beats in arrival order. src_eop is set on the last payload beat
//     (without the feature).
//   - Simultaneous payload FIFO write and read is legal at any occupancy, including full
//     and empty.
//   - Counters are 32-bit and wrap to 0 after 2^32-1.
// CONFIGURATION
//   AVST_RESP_CHECKSUM_EN defined: after PAY, a CSUM beat is sent carrying the modulo-2^DATA_W
//     sum of the stored payload beats; src_eop moves to the CSUM beat. Response = len+2 beats.
//   Not defined: no CSUM state and no adder; response = len+1 beats.
// STRUCTURE
//   avst_resp_pkg: ingress and egress state enums, header bit positions, and the
//     len/status struct {trunc, len}.
//   Sub-module avst_resp_fifo: show-ahead synchronous FIFO, parameters WIDTH and DEPTH,
//     with full and empty outputs. Instantiated twice: payload FIFO and len/status FIFO.
// TESTING
//   1. 4-beat packet 0x11,0x22,0x33,0x44 with src_ready=1 -> 0x00000004 (sop), 0x11..0x44,
//      eop on 0x44; pkt_cnt=1.
//   2. 1-beat packet with sop=eop=1, data 0xA5 -> header 0x00000001, then 0xA5 (eop).
//   3. 300-beat packet with MAX_PKT=256 -> header 0x80000100, first 256 beats echoed;
//      snk_ready stays 1 through beat 300.
//   4. Beat without sop in IDLE, then sop in the middle of a 3-beat packet -> drop_cnt=1;
//      two responses, the first one 2 beats long.
//   5. src_ready held 0 until LEN_DEPTH packets are queued -> snk_ready=0 and no data lost.
//      Release src_ready -> every response matches its request. Randomise ready/valid.
//   6. rst_n pulsed low in the middle of the payload -> all outputs 0 on the next cycle;
//      the next packet's response is correct. With AVST_RESP_CHECKSUM_EN, test 1 additionally
//      ends with checksum 0x000000AA (eop).

Source files
------------

// File: rtl/avst_resp_pkg.sv
// Shared types for the Avalon-ST packet responder: ingress/egress state
// encodings, egress load actions, header layout and the length/status entry.
// Optional feature macro: AVST_RESP_CHECKSUM_EN adds the egress CSUM state.
package avst_resp_pkg;

    // Width of the length field carried in a length/status entry; the
    // responder's derived LEN_W must not exceed it.
    localparam int LEN_FIELD_W = 16;

    // Header word layout: length in the low bits, truncation flag in the MSB.
    localparam int HDR_LEN_LSB = 0;

    typedef enum logic [1:0] {
        ING_IDLE    = 2'd0,
        ING_RECV    = 2'd1,
        ING_DISCARD = 2'd2
    } ing_state_e;

`ifdef AVST_RESP_CHECKSUM_EN
    typedef enum logic [1:0] {
        EGR_IDLE = 2'd0,
        EGR_HDR  = 2'd1,
        EGR_PAY  = 2'd2,
        EGR_CSUM = 2'd3
    } egr_state_e;
`else
    typedef enum logic [1:0] {
        EGR_IDLE = 2'd0,
        EGR_HDR  = 2'd1,
        EGR_PAY  = 2'd2
    } egr_state_e;
`endif

    // What the egress output register loads when it is free.
    typedef enum logic [1:0] {
        ACT_HOLD     = 2'd0,
        ACT_NEXT_PKT = 2'd1,
        ACT_PAY      = 2'd2,
        ACT_CSUM     = 2'd3
    } egr_act_e;

    typedef struct packed {
        logic                   trunc;
        logic [LEN_FIELD_W-1:0] len;
    } len_stat_t;

    function automatic len_stat_t make_len_stat(input logic trunc,
                                                input logic [LEN_FIELD_W-1:0] len);
        len_stat_t e;
        e.trunc = trunc;
        e.len   = len;
        return e;
    endfunction

endpackage

// File: rtl/avst_pkt_responder_if.sv
// One Avalon-ST stream link (data/valid/ready/sop/eop). The master drives
// the beat, the slave drives ready.
interface avst_pkt_responder_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;
    logic              sop;
    logic              eop;

    modport master (output data, output valid, output sop, output eop, input ready);
    modport slave  (input data, input valid, input sop, input eop, output ready);
endinterface

// File: rtl/avst_resp_fifo.sv
// Show-ahead synchronous FIFO. rd_data always presents the oldest entry
// while !empty; rd_en pops it. A write while full is accepted when a pop
// happens in the same cycle. DEPTH must be a power of 2 and >= 2.
module avst_resp_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_wr_s, do_rd_s;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    // Qualify pushes/pops and advance the pointers.
    always_comb begin
        do_rd_s  = rd_en && !empty;
        do_wr_s  = wr_en && (!full || do_rd_s);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr_s) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_rd_s) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/avst_pkt_responder.sv
// FPGA-side end of the HPS<->FPGA Avalon-ST packet link. Request packets are
// stored whole, then answered with a header {trunc, len} followed by the
// echoed payload. Packets longer than MAX_PKT are truncated.
// Optional feature macro: AVST_RESP_CHECKSUM_EN appends a checksum beat
// (modulo-2^DATA_W sum of the payload) that carries eop.
module avst_pkt_responder
    import avst_resp_pkg::*;
#(
    parameter int  DATA_W     = 32,
    parameter int  MAX_PKT    = 256,
    parameter int  DATA_DEPTH = 512,
    parameter int  LEN_DEPTH  = 8,
    localparam int LEN_W      = $clog2(MAX_PKT + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    avst_pkt_responder_if.slave  snk,
    avst_pkt_responder_if.master src,
    output logic [31:0]          pkt_cnt,
    output logic [31:0]          drop_cnt
);
    localparam int LW = $bits(len_stat_t);

    // ---------------- ingress ----------------
    ing_state_e        ing_state_q, ing_state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              pend_q, pend_d;      // 1-beat packet waiting for its length slot
    logic              run_q;               // holds snk_ready low while in reset
    logic [31:0]       drop_cnt_q, drop_cnt_d;
    logic              snk_ready_s, beat_s, room_s;
    logic [LEN_W-1:0]  len_inc_s;

    logic              dfifo_wr_s, dfifo_rd_s, dfifo_full_s, dfifo_empty_s;
    logic [DATA_W-1:0] dfifo_rdata_s;
    logic              lfifo_wr_s, lfifo_rd_s, lfifo_full_s, lfifo_empty_s;
    len_stat_t         lfifo_wdata_s, lfifo_rdata_s;
    logic              unused_len_bits_s;
    logic              unused_dfifo_empty_s;

    // ---------------- egress ----------------
    egr_state_e        egr_state_q, egr_state_d;
    egr_act_e          act_s;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0] src_data_q, src_data_d;
    logic              src_valid_q, src_valid_d;
    logic              src_sop_q, src_sop_d;
    logic              src_eop_q, src_eop_d;
    logic [31:0]       pkt_cnt_q, pkt_cnt_d;
    logic [DATA_W-1:0] hdr_s;
    logic              out_free_s;
`ifdef AVST_RESP_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
`endif

    avst_resp_fifo #(.WIDTH(DATA_W), .DEPTH(DATA_DEPTH)) u_data_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (dfifo_wr_s),
        .wr_data (snk.data),
        .rd_en   (dfifo_rd_s),
        .rd_data (dfifo_rdata_s),
        .full    (dfifo_full_s),
        .empty   (dfifo_empty_s)
    );

    avst_resp_fifo #(.WIDTH(LW), .DEPTH(LEN_DEPTH)) u_len_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (lfifo_wr_s),
        .wr_data (lfifo_wdata_s),
        .rd_en   (lfifo_rd_s),
        .rd_data (lfifo_rdata_s),
        .full    (lfifo_full_s),
        .empty   (lfifo_empty_s)
    );

    // Committed payload is always present before its header is loaded, so
    // the egress side never needs the data FIFO empty flag.
    assign unused_dfifo_empty_s = dfifo_empty_s;
    assign unused_len_bits_s    = |lfifo_rdata_s.len;

    // DISCARD always accepts (beats are dropped); otherwise both FIFOs need room.
    assign room_s      = !dfifo_full_s && !lfifo_full_s;
    assign snk_ready_s = run_q && !pend_q && ((ing_state_q == ING_DISCARD) || room_s);
    assign snk.ready   = snk_ready_s;
    assign beat_s      = snk.valid && snk_ready_s;
    assign len_inc_s   = len_q + LEN_W'(1);

    // Ingress next-state: store payload, commit length/status entries, count orphans.
    always_comb begin
        ing_state_d   = ing_state_q;
        len_d         = len_q;
        pend_d        = pend_q;
        drop_cnt_d    = drop_cnt_q;
        dfifo_wr_s    = 1'b0;
        lfifo_wr_s    = 1'b0;
        lfifo_wdata_s = '0;
        if (pend_q) begin
            // A sop+eop beat in RECV needed two commits; the second goes out now.
            if (!lfifo_full_s) begin
                lfifo_wr_s    = 1'b1;
                lfifo_wdata_s = make_len_stat(1'b0, LEN_FIELD_W'(1));
                pend_d        = 1'b0;
            end else begin
                pend_d        = 1'b1;
            end
        end else if (beat_s) begin
            case (ing_state_q)
                ING_IDLE: begin
                    if (snk.sop) begin
                        dfifo_wr_s = 1'b1;
                        len_d      = LEN_W'(1);
                        if (snk.eop) begin
                            lfifo_wr_s    = 1'b1;
                            lfifo_wdata_s = make_len_stat(1'b0, LEN_FIELD_W'(1));
                            ing_state_d   = ING_IDLE;
                        end else begin
                            ing_state_d   = ING_RECV;
                        end
                    end else begin
                        drop_cnt_d = drop_cnt_q + 32'd1;
                    end
                end
                ING_RECV: begin
                    dfifo_wr_s = 1'b1;
                    if (snk.sop) begin
                        // Close the running packet as-is and restart with this beat.
                        lfifo_wr_s    = 1'b1;
                        lfifo_wdata_s = make_len_stat(1'b0, LEN_FIELD_W'(len_q));
                        len_d         = LEN_W'(1);
                        if (snk.eop) begin
                            pend_d      = 1'b1;
                            ing_state_d = ING_IDLE;
                        end else begin
                            ing_state_d = ING_RECV;
                        end
                    end else begin
                        len_d = len_inc_s;
                        if (snk.eop) begin
                            lfifo_wr_s    = 1'b1;
                            lfifo_wdata_s = make_len_stat(1'b0, LEN_FIELD_W'(len_inc_s));
                            ing_state_d   = ING_IDLE;
                        end else if (len_inc_s == LEN_W'(MAX_PKT)) begin
                            lfifo_wr_s    = 1'b1;
                            lfifo_wdata_s = make_len_stat(1'b1, LEN_FIELD_W'(len_inc_s));
                            ing_state_d   = ING_DISCARD;
                        end else begin
                            ing_state_d   = ING_RECV;
                        end
                    end
                end
                ING_DISCARD: begin
                    if (snk.sop) begin
                        // A new packet; if the FIFOs are full it is lost whole.
                        if (room_s) begin
                            dfifo_wr_s = 1'b1;
                            len_d      = LEN_W'(1);
                            if (snk.eop) begin
                                lfifo_wr_s    = 1'b1;
                                lfifo_wdata_s = make_len_stat(1'b0, LEN_FIELD_W'(1));
                                ing_state_d   = ING_IDLE;
                            end else begin
                                ing_state_d   = ING_RECV;
                            end
                        end else begin
                            ing_state_d = ING_DISCARD;
                        end
                    end else if (snk.eop) begin
                        ing_state_d = ING_IDLE;
                    end else begin
                        ing_state_d = ING_DISCARD;
                    end
                end
                default: begin
                    ing_state_d = ING_IDLE;
                end
            endcase
        end else begin
            ing_state_d = ing_state_q;
        end
    end

    // Ingress state, length and orphan counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ing_state_q <= ING_IDLE;
            len_q       <= '0;
            pend_q      <= 1'b0;
            run_q       <= 1'b0;
            drop_cnt_q  <= 32'd0;
        end else begin
            ing_state_q <= ing_state_d;
            len_q       <= len_d;
            pend_q      <= pend_d;
            run_q       <= 1'b1;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign out_free_s = !src_valid_q || src.ready;

    // Egress next-state: pick what the output register loads, then load it.
    always_comb begin
        egr_state_d = egr_state_q;
        rem_d       = rem_q;
        src_data_d  = src_data_q;
        src_valid_d = src_valid_q;
        src_sop_d   = src_sop_q;
        src_eop_d   = src_eop_q;
        lfifo_rd_s  = 1'b0;
        dfifo_rd_s  = 1'b0;
        act_s       = ACT_HOLD;
`ifdef AVST_RESP_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        hdr_s                            = '0;
        hdr_s[HDR_LEN_LSB +: LEN_W]      = lfifo_rdata_s.len[LEN_W-1:0];
        hdr_s[DATA_W-1]                  = lfifo_rdata_s.trunc;

        if (out_free_s) begin
            case (egr_state_q)
                EGR_IDLE: act_s = ACT_NEXT_PKT;
                EGR_HDR:  act_s = ACT_PAY;
                EGR_PAY: begin
                    if (rem_q != LEN_W'(0)) begin
                        act_s = ACT_PAY;
                    end else begin
`ifdef AVST_RESP_CHECKSUM_EN
                        act_s = ACT_CSUM;
`else
                        act_s = ACT_NEXT_PKT;
`endif
                    end
                end
`ifdef AVST_RESP_CHECKSUM_EN
                EGR_CSUM: act_s = ACT_NEXT_PKT;
`endif
                default:  act_s = ACT_NEXT_PKT;
            endcase
        end else begin
            act_s = ACT_HOLD;
        end

        case (act_s)
            ACT_NEXT_PKT: begin
                if (!lfifo_empty_s) begin
                    lfifo_rd_s  = 1'b1;
                    src_data_d  = hdr_s;
                    src_valid_d = 1'b1;
                    src_sop_d   = 1'b1;
                    src_eop_d   = 1'b0;
                    rem_d       = lfifo_rdata_s.len[LEN_W-1:0];
                    egr_state_d = EGR_HDR;
`ifdef AVST_RESP_CHECKSUM_EN
                    sum_d       = '0;
`endif
                end else begin
                    src_data_d  = '0;
                    src_valid_d = 1'b0;
                    src_sop_d   = 1'b0;
                    src_eop_d   = 1'b0;
                    egr_state_d = EGR_IDLE;
                end
            end
            ACT_PAY: begin
                dfifo_rd_s  = 1'b1;
                src_data_d  = dfifo_rdata_s;
                src_valid_d = 1'b1;
                src_sop_d   = 1'b0;
                rem_d       = rem_q - LEN_W'(1);
                egr_state_d = EGR_PAY;
`ifdef AVST_RESP_CHECKSUM_EN
                src_eop_d   = 1'b0;
                sum_d       = sum_q + dfifo_rdata_s;
`else
                src_eop_d   = (rem_q == LEN_W'(1));
`endif
            end
            ACT_CSUM: begin
`ifdef AVST_RESP_CHECKSUM_EN
                src_data_d  = sum_q;
                src_valid_d = 1'b1;
                src_sop_d   = 1'b0;
                src_eop_d   = 1'b1;
                egr_state_d = EGR_CSUM;
`else
                egr_state_d = EGR_IDLE;
`endif
            end
            default: begin
                egr_state_d = egr_state_q;
            end
        endcase
    end

    // Completed responses: the eop beat of each response is accepted.
    always_comb begin
        if (src_valid_q && src.ready && src_eop_q) begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
        end else begin
            pkt_cnt_d = pkt_cnt_q;
        end
    end

    // Egress state, registered source outputs and response counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            egr_state_q <= EGR_IDLE;
            rem_q       <= '0;
            src_data_q  <= '0;
            src_valid_q <= 1'b0;
            src_sop_q   <= 1'b0;
            src_eop_q   <= 1'b0;
            pkt_cnt_q   <= 32'd0;
`ifdef AVST_RESP_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            egr_state_q <= egr_state_d;
            rem_q       <= rem_d;
            src_data_q  <= src_data_d;
            src_valid_q <= src_valid_d;
            src_sop_q   <= src_sop_d;
            src_eop_q   <= src_eop_d;
            pkt_cnt_q   <= pkt_cnt_d;
`ifdef AVST_RESP_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign src.data  = src_data_q;
    assign src.valid = src_valid_q;
    assign src.sop   = src_sop_q;
    assign src.eop   = src_eop_q;
    assign pkt_cnt   = pkt_cnt_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
